// File: rtl/move_sequencer_if.sv
// Handshake and status bundle between the player front end / datapath and the move sequencer.
// The master side is the front end and datapath; the slave side is the sequencer.
interface move_sequencer_if #(
  parameter int NUM_COLS = 4
);
  logic                  req_valid;
  logic [3:0]            req_column;
  logic                  req_ready;
  logic [3*NUM_COLS-1:0] counters;
  logic [1:0]            game_status;
  logic                  player_turn;
  logic                  move_enable;
  logic [3:0]            move_column;
  logic                  reject;
  logic                  auto_move;
  logic                  game_over;
  logic [1:0]            winner;
  logic [1:0]            state_dbg;

  modport master (
    output req_valid, req_column, counters, game_status, player_turn,
    input  req_ready, move_enable, move_column, reject, auto_move, game_over, winner, state_dbg
  );

  modport slave (
    input  req_valid, req_column, counters, game_status, player_turn,
    output req_ready, move_enable, move_column, reject, auto_move, game_over, winner, state_dbg
  );
endinterface

// File: rtl/move_sequencer.sv
// Move sequencer: validates one column request at a time, pulses the datapath enable,
// waits a settle window for the winner detector and forces a move when a turn times out.
module move_sequencer #(
  parameter int NUM_COLS      = 4,
  parameter int ROWS          = 4,
  parameter int SETTLE_CYCLES = 2,
  parameter int TURN_TIMEOUT  = 1000
) (
  input logic             clk,
  input logic             reset,
  move_sequencer_if.slave bus
);

  localparam int            TW           = (TURN_TIMEOUT > 1) ? $clog2(TURN_TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TIMER_MAX    = {TW{1'b1}};
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TURN_TIMEOUT - 1);
  localparam bit            TIMER_EN     = (TURN_TIMEOUT != 0);
  localparam logic [3:0]    ROWS_L       = 4'(ROWS);
  localparam logic [2:0]    SETTLE_L     = 3'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    ST_WAIT   = 2'b00,
    ST_ISSUE  = 2'b01,
    ST_SETTLE = 2'b10,
    ST_DONE   = 2'b11
  } state_t;

  // Counts above ROWS are treated as full as well.
  function automatic logic col_legal(input logic [3:0] col, input logic [3*NUM_COLS-1:0] cnt);
    logic res;
    res = 1'b0;
    for (int c = 0; c < NUM_COLS; c++) begin
      if (col == 4'(c)) res = ({1'b0, cnt[3*c +: 3]} < ROWS_L);
      else              res = res;
    end
    return res;
  endfunction

  // Returns {found, column} for the lowest-numbered column that still has room.
  function automatic logic [4:0] lowest_legal(input logic [3*NUM_COLS-1:0] cnt);
    logic [4:0] res;
    res = 5'b0_0000;
    for (int c = NUM_COLS - 1; c >= 0; c--) begin
      if ({1'b0, cnt[3*c +: 3]} < ROWS_L) res = {1'b1, 4'(c)};
      else                                res = res;
    end
    return res;
  endfunction

  state_t        state_r;
  logic [TW-1:0] timer_r;
  logic [2:0]    settle_r;
  logic          req_ready_r;
  logic          move_enable_r;
  logic [3:0]    move_column_r;
  logic          reject_r;
  logic          auto_move_r;
  logic          game_over_r;
  logic [1:0]    winner_r;

  logic          accept_s;
  logic          legal_s;
  logic [4:0]    lowest_s;
  logic          timeout_s;
  logic [TW-1:0] timer_inc_s;

  assign accept_s    = bus.req_valid && req_ready_r;
  assign legal_s     = col_legal(bus.req_column, bus.counters);
  assign lowest_s    = lowest_legal(bus.counters);
  // >= rather than == so a reject landing on the last cycle still lets the timeout fire next cycle.
  assign timeout_s   = TIMER_EN && (timer_r >= TIMEOUT_LAST);
  assign timer_inc_s = (timer_r == TIMER_MAX) ? timer_r : timer_r + TW'(1);

  assign bus.req_ready   = req_ready_r;
  assign bus.move_enable = move_enable_r;
  assign bus.move_column = move_column_r;
  assign bus.reject      = reject_r;
  assign bus.auto_move   = auto_move_r;
  assign bus.game_over   = game_over_r;
  assign bus.winner      = winner_r;
  assign bus.state_dbg   = state_r;

  // Sequencer state machine with all outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r       <= ST_WAIT;
      timer_r       <= '0;
      settle_r      <= 3'd0;
      req_ready_r   <= 1'b1;
      move_enable_r <= 1'b0;
      move_column_r <= 4'd0;
      reject_r      <= 1'b0;
      auto_move_r   <= 1'b0;
      game_over_r   <= 1'b0;
      winner_r      <= 2'b00;
    end else begin
      case (state_r)
        ST_WAIT: begin
          reject_r      <= 1'b0;
          move_enable_r <= 1'b0;
          auto_move_r   <= 1'b0;
          if (accept_s) begin
            if (legal_s) begin
              move_column_r <= bus.req_column;
              timer_r       <= '0;
              move_enable_r <= 1'b1;
              req_ready_r   <= 1'b0;
              state_r       <= ST_ISSUE;
            end else begin
              reject_r <= 1'b1;
              timer_r  <= timer_inc_s;
            end
          end else if (timeout_s) begin
            req_ready_r <= 1'b0;
            timer_r     <= '0;
            if (lowest_s[4]) begin
              move_column_r <= lowest_s[3:0];
              move_enable_r <= 1'b1;
              auto_move_r   <= 1'b1;
              state_r       <= ST_ISSUE;
            end else begin
              winner_r    <= 2'b11;
              game_over_r <= 1'b1;
              state_r     <= ST_DONE;
            end
          end else begin
            timer_r <= timer_inc_s;
          end
        end
        ST_ISSUE: begin
          move_enable_r <= 1'b0;
          auto_move_r   <= 1'b0;
          settle_r      <= SETTLE_L;
          state_r       <= ST_SETTLE;
        end
        ST_SETTLE: begin
          settle_r <= settle_r - 3'd1;
          if (settle_r <= 3'd1) begin
            if (bus.game_status != 2'b00) begin
              winner_r    <= bus.game_status;
              game_over_r <= 1'b1;
              state_r     <= ST_DONE;
            end else begin
              timer_r     <= '0;
              req_ready_r <= 1'b1;
              state_r     <= ST_WAIT;
            end
          end else begin
            state_r <= ST_SETTLE;
          end
        end
        ST_DONE: begin
          move_enable_r <= 1'b0;
          reject_r      <= 1'b0;
          auto_move_r   <= 1'b0;
          req_ready_r   <= 1'b0;
          game_over_r   <= 1'b1;
          state_r       <= ST_DONE;
        end
        default: begin
          state_r       <= ST_WAIT;
          timer_r       <= '0;
          req_ready_r   <= 1'b1;
          move_enable_r <= 1'b0;
          reject_r      <= 1'b0;
          auto_move_r   <= 1'b0;
          game_over_r   <= 1'b0;
          winner_r      <= 2'b00;
        end
      endcase
    end
  end

endmodule
